mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single main-memory port between I-cache misses, D-cache misses and D-cache write-through stores.
- Grants one requester at a time and streams an 8-word block fill from the pipelined memory into the granted cache.
- Sits between the IF/MEM cache controllers and the memory module. Its Busy/Done outputs feed the pipeline stall logic.

Parameters:
- BLOCK_WORDS, 8: 16-bit words per cache block. Power of 2. Block base = address with the low log2(BLOCK_WORDS)+1 bits cleared.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- IC_Miss  input  1  I-cache miss request; level, held until IC_FillDone
- IC_MissAddr  input  16  I-cache miss byte address
- DC_Miss  input  1  D-cache miss request; level, held until DC_FillDone
- DC_MissAddr  input  16  D-cache miss byte address
- DC_WrReq  input  1  write-through store request; level, held until DC_WrDone
- DC_WrAddr  input  16  store byte address
- DC_WrData  input  16  store data
- Mem_DataValid  input  1  memory read data valid
- Mem_DataOut  input  16  memory read data
- Mem_En  output  1  memory access enable
- Mem_Wr  output  1  memory write (1) / read (0)
- Mem_Addr  output  16  memory byte address
- Mem_DataIn  output  16  memory write data
- IC_FillWr  output  1  write Fill_Data into the I-cache data array
- DC_FillWr  output  1  write Fill_Data into the D-cache data array
- Fill_Word  output  3  word index within the block for the current fill write
- Fill_Data  output  16  fill data (= Mem_DataOut)
- IC_FillDone  output  1  one-cycle pulse: I-cache block complete
- DC_FillDone  output  1  one-cycle pulse: D-cache block complete
- DC_WrDone  output  1  one-cycle pulse: store issued
- Busy  output  1  state != IDLE

Behaviour:
- States:
  - IDLE: sample requests.
  - WRITE: one cycle, then IDLE.
  - FILL: issue reads and receive data.
  - DONE: one cycle, then IDLE.
- Priority in IDLE, fixed: DC_WrReq > DC_Miss > IC_Miss.
  - Latch the grant owner (IC/DC), block base, and write addr/data into registers on the IDLE->next edge.
  - Requests are ignored in all states other than IDLE.
- WRITE:
  - Mem_En=1, Mem_Wr=1, Mem_Addr=latched DC_WrAddr, Mem_DataIn=latched DC_WrData, DC_WrDone=1.
  - Next state is IDLE.
- FILL:
  - issue_cnt (4b) starts at 0.
  - While issue_cnt<8: Mem_En=1, Mem_Wr=0, Mem_Addr=base|(issue_cnt[2:0]<<1), issue_cnt++. One read per cycle on consecutive cycles.
  - recv_cnt (4b) starts at 0. On each Mem_DataValid: owner's FillWr=1, Fill_Word=recv_cnt[2:0], recv_cnt++.
  - When recv_cnt reaches 8, next state is DONE.
- DONE: owner's FillDone=1 for exactly one cycle, then IDLE. Requesters drop their level on the edge where they see Done.
- Latency with 4-cycle memory, request sampled in cycle T:
  - Mem_En for word 0 at T+1; for word 7 at T+8.
  - Data returns T+5..T+12.
  - FillDone at T+13.
  - Store: DC_WrDone at T+1.
- Requester drops its miss mid-fill: the fill still runs to completion, including all FillWr pulses and FillDone.
- New request arriving while Busy: held by the requester and sampled at the next IDLE. Back-to-back grants have a single IDLE cycle between DONE/WRITE and the next grant.
- Mem_DataValid in IDLE/WRITE/DONE: ignored; no FillWr.
- Outputs in IDLE: all 0, including Mem_Addr, Mem_DataIn and Fill_Word. Fill_Data always follows Mem_DataOut but is qualified only by FillWr.
- Reset (any state, including mid-fill): next edge sets state=IDLE, counters=0, owner cleared; all outputs 0.
  - Memory returns still in flight after reset are ignored.
  - The interrupted requester is re-served from word 0 if its miss is still asserted.
- Never: more than 8 issues per fill; FillWr to the non-owner; two Done pulses per grant.

Test Plan:
- IC_Miss=1, IC_MissAddr=0x1236, memory returns 0xA000+i:
  - Mem_Addr 0x1230,0x1232,...,0x123E on T+1..T+8.
  - IC_FillWr with Fill_Word 0..7 and data 0xA000..0xA007.
  - IC_FillDone single pulse at T+13; DC_FillWr never asserted.
- IC_Miss (0x0100) and DC_Miss (0x4008) raised in the same cycle:
  - DC fill runs first with base 0x4000.
  - IC word 0 (Mem_Addr 0x0100) issued 2 cycles after DC_FillDone.
- DC_WrReq (addr 0x0010, data 0xBEEF), DC_Miss and IC_Miss raised together:
  - One cycle with Mem_Wr=1, Mem_Addr=0x0010, Mem_DataIn=0xBEEF and DC_WrDone=1.
  - Then the DC fill, then the IC fill.
- rst=1 for one cycle after the 4th issued read of an IC fill:
  - All outputs 0 next cycle; the stale DataValid pulses give no FillWr.
  - With IC_Miss held, the fill restarts at word 0 and completes with 8 writes.
- IC_Miss dropped after 2 cycles of FILL: all 8 IC_FillWr pulses and IC_FillDone are still produced.
- Mem_DataValid=1 pulsed while IDLE with no requests: no FillWr, Busy stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between I-cache fills, D-cache fills and
// D-cache write-through stores; streams one block per fill into the owning cache.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            IC_Miss,
  input  logic [15:0]                     IC_MissAddr,
  input  logic                            DC_Miss,
  input  logic [15:0]                     DC_MissAddr,
  input  logic                            DC_WrReq,
  input  logic [15:0]                     DC_WrAddr,
  input  logic [15:0]                     DC_WrData,
  input  logic                            Mem_DataValid,
  input  logic [15:0]                     Mem_DataOut,
  output logic                            Mem_En,
  output logic                            Mem_Wr,
  output logic [15:0]                     Mem_Addr,
  output logic [15:0]                     Mem_DataIn,
  output logic                            IC_FillWr,
  output logic                            DC_FillWr,
  output logic [$clog2(BLOCK_WORDS)-1:0]  Fill_Word,
  output logic [15:0]                     Fill_Data,
  output logic                            IC_FillDone,
  output logic                            DC_FillDone,
  output logic                            DC_WrDone,
  output logic                            Busy
);

  localparam int WIDX = $clog2(BLOCK_WORDS);
  localparam int CW   = WIDX + 1;
  localparam logic [15:0]   BASE_MASK = ~16'(2 * BLOCK_WORDS - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_e;

  state_e          state_q, state_d;
  logic            owner_dc_q, owner_dc_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   recv_cnt_q, recv_cnt_d;
  logic [CW:0]     flush_q, flush_d, flush_rst;
  logic [CW+1:0]   inflight;
  logic [15:0]     base_q, base_d;
  logic [15:0]     waddr_q, waddr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            issue_now, accept;

  assign issue_now = (state_q == FILL) && !issue_cnt_q[CW-1];
  // Returns belonging to a fill killed by reset are swallowed by the flush count.
  assign accept    = (state_q == FILL) && Mem_DataValid && (flush_q == '0)
                     && !recv_cnt_q[CW-1];
  assign Fill_Data = Mem_DataOut;
  assign Busy      = (state_q != IDLE);

  assign inflight = (CW+2)'(flush_q) + (CW+2)'(issue_cnt_q) - (CW+2)'(recv_cnt_q)
                    + (CW+2)'(issue_now);

  always_comb begin
    flush_rst = '0;
    if (state_q == FILL && inflight != '0)
      flush_rst = (CW+1)'(inflight - (CW+2)'(Mem_DataValid));
    flush_d = flush_q;
    if (Mem_DataValid && flush_q != '0)
      flush_d = flush_q - 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    owner_dc_d  = owner_dc_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    base_d      = base_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    Mem_En      = 1'b0;
    Mem_Wr      = 1'b0;
    Mem_Addr    = '0;
    Mem_DataIn  = '0;
    IC_FillWr   = 1'b0;
    DC_FillWr   = 1'b0;
    Fill_Word   = '0;
    IC_FillDone = 1'b0;
    DC_FillDone = 1'b0;
    DC_WrDone   = 1'b0;
    unique case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
        if (DC_WrReq) begin
          state_d    = WRITE;
          owner_dc_d = 1'b1;
          waddr_d    = DC_WrAddr;
          wdata_d    = DC_WrData;
        end else if (DC_Miss) begin
          state_d    = FILL;
          owner_dc_d = 1'b1;
          base_d     = DC_MissAddr & BASE_MASK;
        end else if (IC_Miss) begin
          state_d    = FILL;
          owner_dc_d = 1'b0;
          base_d     = IC_MissAddr & BASE_MASK;
        end
      end
      WRITE: begin
        Mem_En     = 1'b1;
        Mem_Wr     = 1'b1;
        Mem_Addr   = waddr_q;
        Mem_DataIn = wdata_q;
        DC_WrDone  = 1'b1;
        state_d    = IDLE;
      end
      FILL: begin
        if (issue_now) begin
          Mem_En      = 1'b1;
          Mem_Addr    = base_q | 16'({issue_cnt_q[WIDX-1:0], 1'b0});
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (accept) begin
          IC_FillWr  = !owner_dc_q;
          DC_FillWr  = owner_dc_q;
          Fill_Word  = recv_cnt_q[WIDX-1:0];
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST_WORD)
            state_d = DONE;
        end
      end
      DONE: begin
        IC_FillDone = !owner_dc_q;
        DC_FillDone = owner_dc_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_dc_q  <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      flush_q     <= flush_rst;
    end else begin
      state_q     <= state_d;
      owner_dc_q  <= owner_dc_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      flush_q     <= flush_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q  <= base_d;
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined read memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        IC_Miss, DC_Miss, DC_WrReq;
  logic [15:0] IC_MissAddr, DC_MissAddr, DC_WrAddr, DC_WrData;
  logic        Mem_DataValid;
  logic [15:0] Mem_DataOut;
  logic        Mem_En, Mem_Wr;
  logic [15:0] Mem_Addr, Mem_DataIn, Fill_Data;
  logic        IC_FillWr, DC_FillWr, IC_FillDone, DC_FillDone, DC_WrDone, Busy;
  logic [2:0]  Fill_Word;

  logic        extra_vld;
  logic [3:0]  pv = 4'b0;
  logic [15:0] pd0 = '0, pd1 = '0, pd2 = '0, pd3 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .IC_Miss(IC_Miss), .IC_MissAddr(IC_MissAddr),
    .DC_Miss(DC_Miss), .DC_MissAddr(DC_MissAddr),
    .DC_WrReq(DC_WrReq), .DC_WrAddr(DC_WrAddr), .DC_WrData(DC_WrData),
    .Mem_DataValid(Mem_DataValid), .Mem_DataOut(Mem_DataOut),
    .Mem_En(Mem_En), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr), .Mem_DataIn(Mem_DataIn),
    .IC_FillWr(IC_FillWr), .DC_FillWr(DC_FillWr), .Fill_Word(Fill_Word),
    .Fill_Data(Fill_Data), .IC_FillDone(IC_FillDone), .DC_FillDone(DC_FillDone),
    .DC_WrDone(DC_WrDone), .Busy(Busy)
  );

  // Memory: read issued in cycle c returns 0xA000 + word index in cycle c+4.
  always_ff @(posedge clk) begin
    pv  <= {pv[2:0], Mem_En && !Mem_Wr};
    pd0 <= 16'hA000 + {13'b0, Mem_Addr[3:1]};
    pd1 <= pd0;
    pd2 <= pd1;
    pd3 <= pd2;
  end

  assign Mem_DataValid = pv[3] | extra_vld;
  assign Mem_DataOut   = extra_vld ? 16'h5555 : pd3;

  wire [26:0] obs = {Mem_En, Mem_Wr, Mem_Addr, IC_FillWr, DC_FillWr, Fill_Word,
                     IC_FillDone, DC_FillDone, DC_WrDone, Busy};

  // Expected output vector for a fill whose request was sampled in cycle s.
  function automatic logic [26:0] exp_fill(int k, int s, logic dc, logic [15:0] base);
    int d;
    logic en, wr, done, busy;
    logic [15:0] a;
    logic [2:0]  fw;
    d    = k - s;
    en   = (d >= 1 && d <= 8);
    wr   = (d >= 5 && d <= 12);
    done = (d == 13);
    busy = (d >= 1 && d <= 13);
    a    = en ? base + 16'(2 * (d - 1)) : 16'h0;
    fw   = wr ? 3'(d - 5) : 3'd0;
    return {en, 1'b0, a, wr & ~dc, wr & dc, fw, done & ~dc, done & dc, 1'b0, busy};
  endfunction

  task automatic test_reset();
    rst = 1'b1; IC_Miss = 1'b0; DC_Miss = 1'b0; DC_WrReq = 1'b0;
    IC_MissAddr = '0; DC_MissAddr = '0; DC_WrAddr = '0; DC_WrData = '0;
    extra_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== 27'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h, required %h", obs, 27'h0);
    end
    n_cmp++;
    if (Mem_DataIn !== 16'h0) begin
      n_bad++; $display("FAIL reset_datain: got %h, required %h", Mem_DataIn, 16'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== 27'h0) begin
      n_bad++; $display("FAIL post_reset_idle: got %h, required %h", obs, 27'h0);
    end
  endtask

  task automatic test_ic_fill();
    logic [26:0] e;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin IC_Miss = 1'b1; IC_MissAddr = 16'h1236; end
      if (k == 14) IC_Miss = 1'b0;
      @(negedge clk);
      e = exp_fill(k, 0, 1'b0, 16'h1230);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL ic_fill k=%0d: got %h, required %h", k, obs, e);
      end
      if (e[8] | e[7]) begin
        n_cmp++;
        if (Fill_Data !== 16'hA000 + {13'b0, e[6:4]}) begin
          n_bad++; $display("FAIL ic_fill_data k=%0d: got %h, required %h",
                            k, Fill_Data, 16'hA000 + {13'b0, e[6:4]});
        end
      end
    end
  endtask

  task automatic test_dc_before_ic();
    logic [26:0] e;
    for (int k = 0; k <= 28; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        IC_Miss = 1'b1; IC_MissAddr = 16'h0100;
        DC_Miss = 1'b1; DC_MissAddr = 16'h4008;
      end
      if (k == 14) DC_Miss = 1'b0;
      if (k == 28) IC_Miss = 1'b0;
      @(negedge clk);
      e = exp_fill(k, 0, 1'b1, 16'h4000) | exp_fill(k, 14, 1'b0, 16'h0100);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL dc_before_ic k=%0d: got %h, required %h", k, obs, e);
      end
      if (e[8] | e[7]) begin
        n_cmp++;
        if (Fill_Data !== 16'hA000 + {13'b0, e[6:4]}) begin
          n_bad++; $display("FAIL dc_before_ic_data k=%0d: got %h, required %h",
                            k, Fill_Data, 16'hA000 + {13'b0, e[6:4]});
        end
      end
    end
  endtask

  task automatic test_write_first();
    logic [26:0] e;
    logic [15:0] edin;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        DC_WrReq = 1'b1; DC_WrAddr = 16'h0010; DC_WrData = 16'hBEEF;
        DC_Miss = 1'b1; DC_MissAddr = 16'h4008;
        IC_Miss = 1'b1; IC_MissAddr = 16'h0100;
      end
      if (k == 2)  DC_WrReq = 1'b0;
      if (k == 16) DC_Miss = 1'b0;
      if (k == 30) IC_Miss = 1'b0;
      @(negedge clk);
      e = exp_fill(k, 2, 1'b1, 16'h4000) | exp_fill(k, 16, 1'b0, 16'h0100);
      if (k == 1) e = {1'b1, 1'b1, 16'h0010, 2'b00, 3'd0, 2'b00, 1'b1, 1'b1};
      edin = (k == 1) ? 16'hBEEF : 16'h0000;
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL write_first k=%0d: got %h, required %h", k, obs, e);
      end
      n_cmp++;
      if (Mem_DataIn !== edin) begin
        n_bad++; $display("FAIL write_first_datain k=%0d: got %h, required %h",
                          k, Mem_DataIn, edin);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [26:0] e;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin IC_Miss = 1'b1; IC_MissAddr = 16'h2468; end
      rst = (k == 5);
      if (k == 20) IC_Miss = 1'b0;
      @(negedge clk);
      if (k <= 5)       e = exp_fill(k, 0, 1'b0, 16'h2460);
      else if (k == 6)  e = 27'h0;
      else              e = exp_fill(k, 6, 1'b0, 16'h2460);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL reset_mid_fill k=%0d: got %h, required %h", k, obs, e);
      end
      if (e[8] | e[7]) begin
        n_cmp++;
        if (Fill_Data !== 16'hA000 + {13'b0, e[6:4]}) begin
          n_bad++; $display("FAIL reset_mid_fill_data k=%0d: got %h, required %h",
                            k, Fill_Data, 16'hA000 + {13'b0, e[6:4]});
        end
      end
    end
  endtask

  task automatic test_drop_mid_fill();
    logic [26:0] e;
    for (int k = 0; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin IC_Miss = 1'b1; IC_MissAddr = 16'h3000; end
      if (k == 3) IC_Miss = 1'b0;
      @(negedge clk);
      e = exp_fill(k, 0, 1'b0, 16'h3000);
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL drop_mid_fill k=%0d: got %h, required %h", k, obs, e);
      end
    end
  endtask

  task automatic test_idle_valid();
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk); #1;
      extra_vld = (k <= 2);
      @(negedge clk);
      n_cmp++;
      if (obs !== 27'h0) begin
        n_bad++; $display("FAIL idle_valid k=%0d: got %h, required %h", k, obs, 27'h0);
      end
    end
    extra_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ic_fill();
    test_dc_before_ic();
    test_write_first();
    test_reset_mid_fill();
    test_drop_mid_fill();
    test_idle_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
